// File: rtl/dfc_pkg.sv
// Shared constants and configuration helpers for the DFC receiver.
// Holds default sizing, the pointer-width function and the legality check.
package dfc_pkg;

  localparam int DFC_WIDTH = 8;
  localparam int DFC_DEPTH = 8;
  localparam int DFC_DELAY = 3;

  function automatic int dfc_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Legal when depth is a power of two, can absorb the round trip, and asz matches.
  function automatic bit dfc_cfg_ok(input int depth, input int delay, input int asz);
    return (depth > delay) && ((depth & (depth - 32'sd1)) == 32'sd0) &&
           (asz == dfc_clog2(depth));
  endfunction

  localparam bit DFC_DEFAULT_CFG_OK = dfc_cfg_ok(DFC_DEPTH, DFC_DELAY, dfc_clog2(DFC_DEPTH));

endpackage

// File: rtl/dfc_rx_buf.sv
// Dual-pointer register-file FIFO core: storage, read/write pointers and occupancy.
// Pointers wrap naturally because depth is a power of two.
module dfc_rx_buf
  import dfc_pkg::*;
#(
  parameter int width = DFC_WIDTH,
  parameter int depth = DFC_DEPTH,
  parameter int asz   = dfc_clog2(DFC_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic [asz:0]     count,
  output logic [asz:0]     count_next
);

  localparam logic [asz-1:0] PTR_ONE = asz'(1);

  logic [width-1:0] mem_r [depth];
  logic [asz-1:0]   wptr_r;
  logic [asz-1:0]   rptr_r;
  logic [asz:0]     count_r;
  logic [asz:0]     count_next_s;

  // Occupancy after this edge's write and read.
  always_comb begin
    count_next_s = count_r + {{asz{1'b0}}, wr} - {{asz{1'b0}}, rd};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (wr) wptr_r <= wptr_r + PTR_ONE;
      if (rd) rptr_r <= rptr_r + PTR_ONE;
      count_r <= count_next_s;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr) mem_r[wptr_r] <= wdata;
  end

  assign rdata      = mem_r[rptr_r];
  assign count      = count_r;
  assign count_next = count_next_s;

endmodule

// File: rtl/dfc_receiver.sv
// Receiving end of a delayed-flow-control link: skid FIFO plus registered c_fc_n.
// Re-presents buffered beats on a srdy/drdy interface with one cycle of latency.
module dfc_receiver
  import dfc_pkg::*;
#(
  parameter int width = DFC_WIDTH,
  parameter int depth = DFC_DEPTH,
  parameter int delay = DFC_DELAY,
  parameter int asz   = dfc_clog2(DFC_DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             c_vld,
  input  logic [width-1:0] c_data,
  output logic             c_fc_n,
  output logic             p_srdy,
  input  logic             p_drdy,
  output logic [width-1:0] p_data,
  output logic             overflow
);

  localparam bit           CFG_OK  = dfc_cfg_ok(depth, delay, asz);
  localparam logic [asz:0] DEPTH_C = (asz + 1)'(depth);
  localparam logic [asz:0] DELAY_C = (asz + 1)'(delay);

  if (!(CFG_OK && DFC_DEFAULT_CFG_OK)) begin : g_cfg_check
    $error("dfc_receiver: depth must be a power of 2 above delay, asz = log2(depth)");
  end

  logic         rd_s;
  logic         wr_s;
  logic         full_s;
  logic         drop_s;
  logic         fc_next_s;
  logic [asz:0] count_s;
  logic [asz:0] count_next_s;
  logic [asz:0] room_s;
  logic         fc_r;
  logic         overflow_r;

  dfc_rx_buf #(
    .width (width),
    .depth (depth),
    .asz   (asz)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr_s),
    .rd         (rd_s),
    .wdata      (c_data),
    .rdata      (p_data),
    .count      (count_s),
    .count_next (count_next_s)
  );

  // Read/write qualification; a read frees a slot for a same-cycle write at full.
  always_comb begin
    full_s    = (count_s == DEPTH_C);
    rd_s      = p_srdy & p_drdy;
    wr_s      = c_vld & (~full_s | rd_s);
    drop_s    = c_vld & full_s & ~rd_s;
    room_s    = DEPTH_C - count_next_s;
    fc_next_s = (room_s > DELAY_C);
  end

  // Flow-control register and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fc_r       <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      fc_r       <= fc_next_s;
      overflow_r <= overflow_r | drop_s;
    end
  end

  assign p_srdy   = (count_s != '0);
  assign c_fc_n   = fc_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_dfc_receiver.sv
// Directed self-checking bench for dfc_receiver (depth=8, delay=3).
module tb_dfc_receiver;

  logic       clk;
  logic       reset_n;
  logic       c_vld;
  logic [7:0] c_data;
  logic       c_fc_n;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;
  logic       overflow;

  int total;
  int passed;

  dfc_receiver #(.width(8), .depth(8), .delay(3), .asz(3)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .c_vld    (c_vld),
    .c_data   (c_data),
    .c_fc_n   (c_fc_n),
    .p_srdy   (p_srdy),
    .p_drdy   (p_drdy),
    .p_data   (p_data),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    c_vld   = 1'b0;
    c_data  = 8'h00;
    p_drdy  = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    p_drdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      c_vld  = 1'b1;
      c_data = base + 8'(i);
      step();
    end
    c_vld = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    c_vld   = 1'b0;
    c_data  = 8'h00;
    p_drdy  = 1'b0;
    step();
    step();
    total++; if (p_srdy !== 1'b0) $display("FAIL reset_srdy got=%b exp=0", p_srdy); else passed++;
    total++; if (c_fc_n !== 1'b0) $display("FAIL reset_fc got=%b exp=0", c_fc_n); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow); else passed++;
    reset_n = 1'b1;
    #2;
    total++; if (c_fc_n !== 1'b0) $display("FAIL release_fc_pre got=%b exp=0", c_fc_n); else passed++;
    step();
    total++; if (c_fc_n !== 1'b1) $display("FAIL release_fc_post got=%b exp=1", c_fc_n); else passed++;
  endtask

  task automatic test_single();
    c_vld  = 1'b1;
    c_data = 8'hA5;
    p_drdy = 1'b1;
    step();
    c_vld = 1'b0;
    total++; if (p_srdy !== 1'b1) $display("FAIL single_srdy got=%b exp=1", p_srdy); else passed++;
    total++; if (p_data !== 8'hA5) $display("FAIL single_data got=%h exp=a5", p_data); else passed++;
    step();
    total++; if (p_srdy !== 1'b0) $display("FAIL single_empty got=%b exp=0", p_srdy); else passed++;
    total++; if (c_fc_n !== 1'b1) $display("FAIL single_fc got=%b exp=1", c_fc_n); else passed++;
  endtask

  task automatic test_threshold();
    logic exp_fc;
    p_drdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c_vld  = 1'b1;
      c_data = 8'(i);
      step();
      exp_fc = (i + 1 <= 4);
      total++; if (c_fc_n !== exp_fc) $display("FAIL fill_fc[%0d] got=%b exp=%b", i, c_fc_n, exp_fc); else passed++;
    end
    c_vld = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL thresh_ovf got=%b exp=0", overflow); else passed++;
    p_drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (p_srdy !== 1'b1 || p_data !== 8'(i))
        $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, p_srdy, p_data, 8'(i)); else passed++;
      step();
      exp_fc = ((7 - i) <= 4);
      total++; if (c_fc_n !== exp_fc) $display("FAIL drain_fc[%0d] got=%b exp=%b", i, c_fc_n, exp_fc); else passed++;
    end
    total++; if (p_srdy !== 1'b0) $display("FAIL thresh_empty got=%b exp=0", p_srdy); else passed++;
    p_drdy = 1'b0;
  endtask

  task automatic test_overflow();
    fill(8, 8'h00);
    c_vld  = 1'b1;
    c_data = 8'hFF;
    step();
    c_vld = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set got=%b exp=1", overflow); else passed++;
    step();
    total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", overflow); else passed++;
    p_drdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (p_srdy !== 1'b1 || p_data !== 8'(i))
        $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, p_srdy, p_data, 8'(i)); else passed++;
      step();
    end
    total++; if (p_srdy !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", p_srdy); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_hold got=%b exp=1", overflow); else passed++;
    do_reset();
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clear got=%b exp=0", overflow); else passed++;
  endtask

  task automatic test_full_rw();
    logic [7:0] exp_q [$];
    fill(8, 8'h00);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h55);
    p_drdy = 1'b1;
    c_vld  = 1'b1;
    c_data = 8'h55;
    total++; if (p_data !== 8'h00) $display("FAIL rw_head got=%h exp=00", p_data); else passed++;
    step();
    c_vld = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL rw_ovf got=%b exp=0", overflow); else passed++;
    total++; if (c_fc_n !== 1'b0) $display("FAIL rw_fc got=%b exp=0", c_fc_n); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++; if (p_srdy !== 1'b1 || p_data !== exp_q[i])
        $display("FAIL rw_drain[%0d] got=%b/%h exp=1/%h", i, p_srdy, p_data, exp_q[i]); else passed++;
      step();
    end
    total++; if (p_srdy !== 1'b0) $display("FAIL rw_empty got=%b exp=0", p_srdy); else passed++;
    p_drdy = 1'b0;
  endtask

  task automatic test_back_to_back();
    p_drdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      c_vld  = 1'b1;
      c_data = 8'h10 + 8'(i);
      step();
      total++; if (p_srdy !== 1'b1 || p_data !== 8'h10 + 8'(i))
        $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, p_srdy, p_data, 8'h10 + 8'(i)); else passed++;
      total++; if (c_fc_n !== 1'b1) $display("FAIL b2b_fc[%0d] got=%b exp=1", i, c_fc_n); else passed++;
    end
    c_vld = 1'b0;
    step();
    total++; if (p_srdy !== 1'b0) $display("FAIL b2b_empty got=%b exp=0", p_srdy); else passed++;
    p_drdy = 1'b0;
  endtask

  task automatic test_async_reset();
    fill(4, 8'h40);
    total++; if (p_srdy !== 1'b1 || c_fc_n !== 1'b1)
      $display("FAIL ar_pre got=%b/%b exp=1/1", p_srdy, c_fc_n); else passed++;
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (p_srdy !== 1'b0) $display("FAIL ar_srdy got=%b exp=0", p_srdy); else passed++;
    total++; if (c_fc_n !== 1'b0) $display("FAIL ar_fc got=%b exp=0", c_fc_n); else passed++;
    step();
    reset_n = 1'b1;
    step();
    total++; if (p_srdy !== 1'b0) $display("FAIL ar_empty got=%b exp=0", p_srdy); else passed++;
    total++; if (c_fc_n !== 1'b1) $display("FAIL ar_fc_post got=%b exp=1", c_fc_n); else passed++;
  endtask

  initial begin
    total   = 0;
    passed  = 0;
    reset_n = 1'b0;
    c_vld   = 1'b0;
    c_data  = 8'h00;
    p_drdy  = 1'b0;
    test_reset();
    test_single();
    test_threshold();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
